multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Parametrised, sequential successor to the single-cycle decoder for the CSE-BUBBLE datapath. It fetches through a handshake and walks each instruction through FETCH → DECODE → EXECUTE → [MEM] → WRITEBACK, registering the decoded controls. It adds the following over the single-cycle decoder:
- data-memory and instruction-memory stalls;
- configurable immediate extension;
- jump-and-link;
- a memory timeout;
- halt and illegal-opcode handling.

It sits between instruction memory, the register file, the ALU, the data memory and the PC logic.

## Interface
Parameters:
- DATA_W, 32: datapath width. Must be at least 32.
- IMM_SIGN_EXT, 1: 1 sign-extends instr[15:0] to DATA_W; 0 zero-extends it.
- MEM_TIMEOUT, 0: maximum number of MEM cycles to wait for data_mem_ready. 0 disables the timeout.

Ports (name, direction, width, meaning):
- clk in 1: the single clock. All state changes on the rising edge.
- rst_n in 1: reset, synchronous, active-low.
- instr_req out 1: fetch request.
- instr_valid in 1: instruction word is present.
- instruction in 32: instruction word.
- pc_plus1 in DATA_W: link value used by jal.
- regin1, regin2 in DATA_W: register-file read data for IR rs/rt.
- aluout1, aluout2 out DATA_W: ALU operands.
- aluin in DATA_W: ALU result.
- alu_cond in 1: ALU branch-condition result.
- regout out DATA_W: register write data.
- write_enable out 1: register write strobe.
- branch out 1: take the branch or jump.
- offset out DATA_W: branch/jump offset or target.
- pc_update out 1: the instruction is retired; the PC advances.
- data_mem_req out 1: data memory request.
- data_mem_write_enable out 1: data memory write.
- data_mem_ready in 1: data memory completion.
- data_mem_base_address, data_mem_offset, data_mem_write_data out DATA_W: data memory address and write data.
- data_mem_read_data in DATA_W: data memory read data.
- halted out 1: the block is in HALT.
- illegal out 1: illegal-opcode pulse.
- mem_error out 1: memory-timeout pulse.

## Operation
The opcode is op = IR[31:26]. Opcode classes:
- ALU-R: op 0–3, 6, 7, 23. aluout2 = regin2.
- ALU-I: op 4, 5, 8–11, 24. aluout2 = extended IR[15:0].
- LOAD: op 12.
- STORE: op 13.
- BRANCH: op 14–19.
- J: op 20.
- JR: op 21.
- JAL: op 22.
- HALT: op 63.
- ILLEGAL: op 25–62.

Datapath assignments:
- aluout1 = regin1 in every class.
- Memory address: base = regin1, offset = extended IR[15:0]. Store data = regin2.
- BRANCH offset = {IR[25:21], IR[15:0]}, sign-extended from bit 20 regardless of IMM_SIGN_EXT.
- J and JAL offset = IR[25:0], zero-extended.
- JR offset = regin1.

States and transitions:
- FETCH: instr_req = 1. When instr_valid = 1, latch the instruction into IR and go to DECODE.
- DECODE: one cycle. Register the opcode class. HALT goes to HALT; every other class goes to EXECUTE.
- EXECUTE: one cycle. Drive aluout1/aluout2 and capture aluin, alu_cond, regin1/regin2 and pc_plus1. LOAD and STORE go to MEM; all others go to WB.
- MEM: hold data_mem_req = 1 and the address/data steady; data_mem_write_enable = 1 for STORE. On data_mem_ready, capture data_mem_read_data (LOAD) and go to WB.
  - Timeout (MEM_TIMEOUT > 0): the MEM cycle counter reaches MEM_TIMEOUT without data_mem_ready. Drop data_mem_req, pulse mem_error for 1 cycle, suppress the register write, and go to FETCH without pc_update.
- WB: one cycle, then FETCH. pc_update = 1 always. Per class:
  - ALU-R/ALU-I: write_enable = 1, regout = captured aluin.
  - LOAD: write_enable = 1, regout = read data.
  - JAL: write_enable = 1, regout = pc_plus1, branch = 1.
  - BRANCH: branch = captured alu_cond.
  - J/JR: branch = 1.
  - STORE: no register write.
  - ILLEGAL: illegal = 1, no write, no branch.
- HALT: halted = 1. Stays in HALT until reset; every other output is 0.

General rules:
- write_enable, branch, pc_update, illegal and mem_error are single-cycle pulses.
- offset is valid whenever branch = 1.

## Timing
- Reset: rst_n = 0 at a rising edge forces FETCH from any state, including mid-MEM. The request is abandoned and no write occurs. The following outputs are 0:
  - IR
  - write_enable, branch, pc_update
  - data_mem_req, data_mem_write_enable
  - halted, illegal, mem_error
  - every data output
- instr_req is asserted in the first cycle after reset is released.
- Latency, with the fetch accepted at edge T:
  - ALU, branch and jump instructions: WB is the cycle after edge T+2; the next instr_req follows in the cycle after WB.
  - LOAD/STORE: WB is the cycle after data_mem_ready is sampled. Minimum total is 5 cycles per instruction.
- instr_valid is ignored outside FETCH. data_mem_ready is ignored outside MEM.
- data_mem_ready in the first MEM cycle completes the access in 1 cycle.
- Timeout boundary: if the timeout and data_mem_ready coincide, ready wins.

## Test plan
- ALU-I: IMM_SIGN_EXT = 1, instr 0x1000FFFF, regin1 = 5, aluin = 4. Required: aluout2 = 0xFFFFFFFF in EXECUTE; then one WB cycle with write_enable = 1, regout = 4, pc_update = 1.
- LOAD: instr 0x30000008, data_mem_ready asserted after 3 MEM cycles, read data 0xDEADBEEF. Required: data_mem_req high for exactly 3 cycles, data_mem_offset = 8, then WB with regout = 0xDEADBEEF.
- BRANCH and JAL:
  - Instr 0x38200010 with alu_cond = 1. Required: branch = 1, offset = 0x00010010, write_enable = 0.
  - Instr 0x58000040 (JAL) with pc_plus1 = 7. Required: branch = 1, offset = 0x40, regout = 7, write_enable = 1.
- Timeout: MEM_TIMEOUT = 4, STORE with data_mem_ready never asserted. Required: data_mem_req high for 4 cycles, then mem_error = 1 for 1 cycle, no pc_update, return to FETCH.
- Reset and halt:
  - rst_n = 0 in the second MEM cycle. Required: all outputs 0, then instr_req the cycle after release.
  - Instr 0xFC000000. Required: halted = 1 stays high and instr_req stays 0.
- ILLEGAL: instr 0x64000000 (op 25). Required: illegal = 1 and pc_update = 1 in WB, write_enable = 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit for the CSE-BUBBLE datapath: handshake fetch, then
// DECODE -> EXECUTE -> [MEM] -> WB with every control output registered.
module multicycle_control_unit #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned IMM_SIGN_EXT = 1,
  parameter int unsigned MEM_TIMEOUT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              instr_req,
  input  logic              instr_valid,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] pc_plus1,
  input  logic [DATA_W-1:0] regin1,
  input  logic [DATA_W-1:0] regin2,
  output logic [DATA_W-1:0] aluout1,
  output logic [DATA_W-1:0] aluout2,
  input  logic [DATA_W-1:0] aluin,
  input  logic              alu_cond,
  output logic [DATA_W-1:0] regout,
  output logic              write_enable,
  output logic              branch,
  output logic [DATA_W-1:0] offset,
  output logic              pc_update,
  output logic              data_mem_req,
  output logic              data_mem_write_enable,
  input  logic              data_mem_ready,
  output logic [DATA_W-1:0] data_mem_base_address,
  output logic [DATA_W-1:0] data_mem_offset,
  output logic [DATA_W-1:0] data_mem_write_data,
  input  logic [DATA_W-1:0] data_mem_read_data,
  output logic              halted,
  output logic              illegal,
  output logic              mem_error
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BRANCH,
    C_J, C_JR, C_JAL, C_HALT, C_ILLEGAL
  } op_class_t;

  state_t           state;
  op_class_t        op_class;
  op_class_t        op_class_d;
  logic [31:0]      ir;
  logic [CNT_W-1:0] mem_cnt;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] br_off;
  logic [DATA_W-1:0] jmp_off;

  always_comb begin
    op_class_d = C_ILLEGAL;
    case (ir[31:26])
      6'd0, 6'd1, 6'd2, 6'd3, 6'd6, 6'd7, 6'd23:   op_class_d = C_ALU_R;
      6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd11, 6'd24: op_class_d = C_ALU_I;
      6'd12:                                       op_class_d = C_LOAD;
      6'd13:                                       op_class_d = C_STORE;
      6'd14, 6'd15, 6'd16, 6'd17, 6'd18, 6'd19:    op_class_d = C_BRANCH;
      6'd20:                                       op_class_d = C_J;
      6'd21:                                       op_class_d = C_JR;
      6'd22:                                       op_class_d = C_JAL;
      6'd63:                                       op_class_d = C_HALT;
      default:                                     op_class_d = C_ILLEGAL;
    endcase
  end

  always_comb begin
    if (IMM_SIGN_EXT != 0) imm_ext = {{(DATA_W-16){ir[15]}}, ir[15:0]};
    else                   imm_ext = {{(DATA_W-16){1'b0}}, ir[15:0]};
    // Branch displacement always sign-extends from its 21-bit field.
    br_off  = {{(DATA_W-21){ir[25]}}, ir[25:21], ir[15:0]};
    jmp_off = {{(DATA_W-26){1'b0}}, ir[25:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                 <= S_FETCH;
      op_class              <= C_ALU_R;
      ir                    <= '0;
      mem_cnt               <= '0;
      instr_req             <= 1'b0;
      aluout1               <= '0;
      aluout2               <= '0;
      regout                <= '0;
      write_enable          <= 1'b0;
      branch                <= 1'b0;
      offset                <= '0;
      pc_update             <= 1'b0;
      data_mem_req          <= 1'b0;
      data_mem_write_enable <= 1'b0;
      data_mem_base_address <= '0;
      data_mem_offset       <= '0;
      data_mem_write_data   <= '0;
      halted                <= 1'b0;
      illegal               <= 1'b0;
      mem_error             <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      branch       <= 1'b0;
      pc_update    <= 1'b0;
      illegal      <= 1'b0;
      mem_error    <= 1'b0;
      case (state)
        S_FETCH: begin
          if (!instr_req) begin
            instr_req <= 1'b1;
          end else if (instr_valid) begin
            ir        <= instruction;
            instr_req <= 1'b0;
            state     <= S_DECODE;
          end
        end
        S_DECODE: begin
          op_class <= op_class_d;
          if (op_class_d == C_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            aluout1 <= regin1;
            aluout2 <= (op_class_d == C_ALU_I) ? imm_ext : regin2;
            state   <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          aluout1 <= '0;
          aluout2 <= '0;
          if (op_class == C_LOAD || op_class == C_STORE) begin
            data_mem_req          <= 1'b1;
            data_mem_write_enable <= (op_class == C_STORE);
            data_mem_base_address <= regin1;
            data_mem_offset       <= imm_ext;
            data_mem_write_data   <= (op_class == C_STORE) ? regin2 : '0;
            mem_cnt               <= '0;
            state                 <= S_MEM;
          end else begin
            pc_update <= 1'b1;
            state     <= S_WB;
            case (op_class)
              C_ALU_R, C_ALU_I: begin
                write_enable <= 1'b1;
                regout       <= aluin;
              end
              C_JAL: begin
                write_enable <= 1'b1;
                regout       <= pc_plus1;
                branch       <= 1'b1;
                offset       <= jmp_off;
              end
              C_BRANCH: begin
                branch <= alu_cond;
                offset <= br_off;
              end
              C_J: begin
                branch <= 1'b1;
                offset <= jmp_off;
              end
              C_JR: begin
                branch <= 1'b1;
                offset <= regin1;
              end
              default: illegal <= 1'b1;
            endcase
          end
        end
        S_MEM: begin
          // Ready is checked first so it wins over a coinciding timeout.
          if (data_mem_ready || (MEM_TIMEOUT != 0 && mem_cnt == TO_LAST)) begin
            data_mem_req          <= 1'b0;
            data_mem_write_enable <= 1'b0;
            data_mem_base_address <= '0;
            data_mem_offset       <= '0;
            data_mem_write_data   <= '0;
            if (data_mem_ready) begin
              pc_update <= 1'b1;
              state     <= S_WB;
              if (op_class == C_LOAD) begin
                write_enable <= 1'b1;
                regout       <= data_mem_read_data;
              end
            end else begin
              mem_error <= 1'b1;
              instr_req <= 1'b1;
              state     <= S_FETCH;
            end
          end else begin
            mem_cnt <= mem_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          regout    <= '0;
          offset    <= '0;
          instr_req <= 1'b1;
          state     <= S_FETCH;
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: directed instructions push
// expected WB and memory-burst records; a negedge monitor pops and compares.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req, instr_valid;
  logic [31:0] instruction, pc_plus1, regin1, regin2, aluout1, aluout2, aluin;
  logic        alu_cond;
  logic [31:0] regout, offset;
  logic        write_enable, branch, pc_update;
  logic        data_mem_req, data_mem_write_enable, data_mem_ready;
  logic [31:0] data_mem_base_address, data_mem_offset, data_mem_write_data, data_mem_read_data;
  logic        halted, illegal, mem_error;

  multicycle_control_unit #(.DATA_W(32), .IMM_SIGN_EXT(1), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_req(instr_req), .instr_valid(instr_valid),
    .instruction(instruction), .pc_plus1(pc_plus1), .regin1(regin1), .regin2(regin2),
    .aluout1(aluout1), .aluout2(aluout2), .aluin(aluin), .alu_cond(alu_cond),
    .regout(regout), .write_enable(write_enable), .branch(branch), .offset(offset),
    .pc_update(pc_update), .data_mem_req(data_mem_req),
    .data_mem_write_enable(data_mem_write_enable), .data_mem_ready(data_mem_ready),
    .data_mem_base_address(data_mem_base_address), .data_mem_offset(data_mem_offset),
    .data_mem_write_data(data_mem_write_data), .data_mem_read_data(data_mem_read_data),
    .halted(halted), .illegal(illegal), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we, br, pcu, ill, merr;
    logic [31:0] regout, offset;
  } wb_t;

  typedef struct {
    int          len;
    logic        we;
    logic [31:0] base, off, wdata;
  } mem_t;

  wb_t  wb_q[$];
  mem_t mem_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   mem_lat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wb(input logic we, br, pcu, ill, merr, input logic [31:0] ro, off);
    wb_t e;
    e.we = we; e.br = br; e.pcu = pcu; e.ill = ill; e.merr = merr;
    e.regout = ro; e.offset = off;
    wb_q.push_back(e);
  endtask

  task automatic push_mem(input int len, input logic we, input logic [31:0] base, off, wd);
    mem_t e;
    e.len = len; e.we = we; e.base = base; e.off = off; e.wdata = wd;
    mem_q.push_back(e);
  endtask

  // Data-memory responder: ready in MEM cycle mem_lat (0 = never).
  initial begin
    int cyc;
    cyc = 0;
    data_mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (data_mem_req) begin
        cyc++;
        data_mem_ready = (mem_lat != 0 && cyc == mem_lat);
      end else begin
        cyc = 0;
        data_mem_ready = 1'b0;
      end
    end
  end

  // Monitor: WB/timeout pulses and data-memory request bursts.
  initial begin
    wb_t  w;
    mem_t m;
    int   run;
    logic cap_we;
    logic [31:0] cap_base, cap_off, cap_wd;
    run = 0;
    cap_we = 1'b0; cap_base = '0; cap_off = '0; cap_wd = '0;
    forever begin
      @(negedge clk);
      if (write_enable | branch | pc_update | illegal | mem_error) begin
        if (wb_q.size() == 0) begin
          check("wb_unexpected", 32'({write_enable, branch, pc_update, illegal, mem_error}), 32'd0);
        end else begin
          w = wb_q.pop_front();
          check("wb_pulses", 32'({write_enable, branch, pc_update, illegal, mem_error}),
                32'({w.we, w.br, w.pcu, w.ill, w.merr}));
          if (w.we) check("wb_regout", regout, w.regout);
          if (w.br) check("wb_offset", offset, w.offset);
        end
      end
      if (data_mem_req) begin
        if (run == 0) begin
          cap_we = data_mem_write_enable; cap_base = data_mem_base_address;
          cap_off = data_mem_offset; cap_wd = data_mem_write_data;
        end
        run++;
      end else if (run > 0) begin
        if (mem_q.size() == 0) begin
          check("mem_unexpected", 32'(run), 32'd0);
        end else begin
          m = mem_q.pop_front();
          check("mem_len", 32'(run), 32'(m.len));
          check("mem_we", 32'(cap_we), 32'(m.we));
          check("mem_base", cap_base, m.base);
          check("mem_offset", cap_off, m.off);
          if (m.we) check("mem_wdata", cap_wd, m.wdata);
        end
        run = 0;
      end
    end
  end

  task automatic run(input logic [31:0] w, r1, r2, alu, pcp, rd, input logic cond, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_req && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) check("fetch_timeout", 32'(instr_req), 32'd1);
    instruction = w; regin1 = r1; regin2 = r2; aluin = alu; pc_plus1 = pcp;
    data_mem_read_data = rd; alu_cond = cond; mem_lat = lat;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  function automatic logic all_zero();
    return ~|{instr_req, aluout1, aluout2, regout, write_enable, branch, offset, pc_update,
              data_mem_req, data_mem_write_enable, data_mem_base_address, data_mem_offset,
              data_mem_write_data, halted, illegal, mem_error};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instruction = '0; pc_plus1 = '0; regin1 = '0;
    regin2 = '0; aluin = '0; alu_cond = 1'b0; data_mem_read_data = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs_zero", 32'(all_zero()), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("instr_req_after_reset", 32'(instr_req), 32'd1);

    // ALU-I, negative immediate sign-extended
    push_wb(1, 0, 1, 0, 0, 32'd4, '0);
    run(32'h1000FFFF, 32'd5, 32'd0, 32'd4, 32'd0, 32'd0, 1'b0, 0);
    repeat (2) @(negedge clk);
    check("alui_aluout1", aluout1, 32'd5);
    check("alui_aluout2", aluout2, 32'hFFFFFFFF);

    // ALU-R: operand 2 from the register file
    push_wb(1, 0, 1, 0, 0, 32'h99, '0);
    run(32'h00000000, 32'd3, 32'h1234, 32'h99, 32'd0, 32'd0, 1'b0, 0);
    repeat (2) @(negedge clk);
    check("alur_aluout2", aluout2, 32'h1234);

    // LOAD, ready in third MEM cycle
    push_mem(3, 0, 32'h100, 32'd8, 32'd0);
    push_wb(1, 0, 1, 0, 0, 32'hDEADBEEF, '0);
    run(32'h30000008, 32'h100, 32'd0, 32'd0, 32'd0, 32'hDEADBEEF, 1'b0, 3);

    // LOAD, ready in first MEM cycle, negative offset
    push_mem(1, 0, 32'h40, 32'hFFFFFFFC, 32'd0);
    push_wb(1, 0, 1, 0, 0, 32'h55, '0);
    run(32'h3000FFFC, 32'h40, 32'd0, 32'd0, 32'd0, 32'h55, 1'b0, 1);

    // BRANCH taken, positive and negative displacement; not taken
    push_wb(0, 1, 1, 0, 0, '0, 32'h00010010);
    run(32'h38200010, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 0);
    push_wb(0, 1, 1, 0, 0, '0, 32'hFFFF8000);
    run(32'h3FE08000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 0);
    push_wb(0, 0, 1, 0, 0, '0, '0);
    run(32'h38200010, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0);

    // JAL, J, JR
    push_wb(1, 1, 1, 0, 0, 32'd7, 32'h40);
    run(32'h58000040, 32'd0, 32'd0, 32'd0, 32'd7, 32'd0, 1'b0, 0);
    push_wb(0, 1, 1, 0, 0, '0, 32'h03FFFFFF);
    run(32'h53FFFFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0);
    push_wb(0, 1, 1, 0, 0, '0, 32'hABCD0000);
    run(32'h54000000, 32'hABCD0000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0);

    // ILLEGAL opcode 25
    push_wb(0, 0, 1, 1, 0, '0, '0);
    run(32'h64000000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0);

    // STORE timeout, then STORE where ready meets the timeout cycle
    push_mem(4, 1, 32'h200, 32'h10, 32'hCAFE);
    push_wb(0, 0, 0, 0, 1, '0, '0);
    run(32'h34000010, 32'h200, 32'hCAFE, 32'd0, 32'd0, 32'd0, 1'b0, 0);
    push_mem(4, 1, 32'h300, 32'h20, 32'hBEEF);
    push_wb(0, 0, 1, 0, 0, '0, '0);
    run(32'h34000020, 32'h300, 32'hBEEF, 32'd0, 32'd0, 32'd0, 1'b0, 4);

    // Reset asserted in the second MEM cycle of a STORE
    push_mem(2, 1, 32'h400, 32'h4, 32'h77);
    run(32'h34000004, 32'h400, 32'h77, 32'd0, 32'd0, 32'd0, 1'b0, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midmem_reset_zero", 32'(all_zero()), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("midmem_instr_req_after", 32'(instr_req), 32'd1);

    // HALT is sticky
    run(32'hFC000000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0);
    instr_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("halt_state", 32'({halted, instr_req}), 32'b10);
    end
    instr_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    check("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
